motor_pwm_ctrl: RTL and testbench
=================================

Name: motor_pwm_ctrl

Overview:
Next-generation H-bridge driver for the rover drive train.
- Replaces the fixed two-motor stop/right/left/forward decode with NUM_MOTORS independent channels.
- Each channel has its own mode, PWM speed control, shoot-through dead-time on direction reversal and braking, and an emergency stop.
- Sits between the navigation FSM (command source) and the motor-driver pins.

Parameters:
NUM_MOTORS, 2, number of H-bridge channels
DUTY_W, 8, duty resolution in bits; PWM period = 2^DUTY_W-1 ticks
PWM_DIV, 1, clocks per PWM tick (>=1)
DEADTIME, 16, clocks both bridge inputs are held low on a hazardous transition (>=1)

Ports:
clk  in  1  system clock
rst  in  1  reset
cmd_valid  in  1  command strobe
cmd_ready  out  1  block can accept a command
cmd_mask  in  NUM_MOTORS  channels updated by this command
cmd_mode  in  2*NUM_MOTORS  per-channel mode: 00 coast, 01 forward, 10 reverse, 11 brake
cmd_duty  in  DUTY_W*NUM_MOTORS  per-channel duty, 0 = off, 2^DUTY_W-1 = 100%
estop  in  1  emergency stop, level-sensitive
m_f  out  NUM_MOTORS  bridge forward input per channel
m_b  out  NUM_MOTORS  bridge backward input per channel
busy  out  NUM_MOTORS  channel is in dead-time

Behaviour:
Clock and reset
- One clock, clk. Reset rst is synchronous and active-high.
- Reset values: m_f=0, m_b=0, busy=0, cmd_ready=1 (first cycle after rst drops), PWM counter=0, all duty registers=0, all channels COAST.
- Reset mid-operation aborts dead-time and drives outputs to 0 on the next edge.

PWM timing
- Prescaler counts 0..PWM_DIV-1 and issues a tick on terminal count.
- PWM counter cnt advances on each tick over 0..2^DUTY_W-2 and wraps to 0.
- pwm_on = (active_duty > cnt).

Command handshake
- A command is accepted at edge E when cmd_valid & cmd_ready.
- For each channel with cmd_mask=1, mode and duty are captured.
- Duty goes to a shadow register and is copied to active_duty at the next cnt wrap, so periods never glitch.
- cmd_valid while cmd_ready=0 is ignored; the source must hold the command.
- cmd_ready = ~estop & ~|busy.

Per-channel FSM (states COAST, FWD, REV, BRAKE, DEAD)
- The FSM state updates at E. Outputs are registered and reflect the new state at E+1.
- COAST: m_f=0, m_b=0. From COAST, any target is entered immediately.
- FWD: m_f=pwm_on, m_b=0.
- REV: m_f=0, m_b=pwm_on.
- BRAKE: m_f=1, m_b=1, steady; duty is ignored.
- FWD<->REV, FWD/REV->BRAKE and BRAKE->FWD/REV go through DEAD:
  - the target is latched and the dead counter is loaded with DEADTIME-1;
  - outputs are 0 and busy=1 for exactly DEADTIME cycles, then the channel enters the target.
- Any state -> COAST is immediate.
- Same-mode re-command: no state change; only the duty shadow is updated.
- Channels with cmd_mask=0 are unaffected.

Emergency stop
- estop=1 forces every channel to COAST and clears dead counters. Outputs are 0 from the next edge.
- Commands are refused while estop=1.
- On release, channels stay in COAST until commanded.

Simultaneous events
- rst > estop > command.
- A duty write coinciding with a cnt wrap takes effect at that wrap.

Decomposition:
- Package motor_pkg holds:
  - mode localparams MODE_COAST/FWD/REV/BRAKE;
  - channel state encoding;
  - function deadtime_needed(cur, tgt).
- Sub-module motor_channel: per-channel FSM, dead counter, duty shadow/active registers, output registers. Instantiated NUM_MOTORS times by generate.
- Top level holds the prescaler, PWM counter, wrap pulse and handshake.

Test Plan:
Bench configuration: NUM_MOTORS=2, DUTY_W=4 (period 15), PWM_DIV=1, DEADTIME=4.
1. Reset: rst=1 for 2 cycles -> m_f=00, m_b=00, busy=00, cmd_ready=1 one cycle after release.
2. mask=01, ch0 FWD, duty 5 -> after the next wrap, m_f[0] high 5 of every 15 cycles and m_b[0]=0. Duty 15 -> m_f[0] constantly 1. Duty 0 -> constantly 0.
3. ch0 FWD -> REV -> m_f[0]=m_b[0]=0, busy[0]=1 and cmd_ready=0 for exactly 4 cycles, then m_b[0] PWMs at the latched duty.
4. cmd_valid during dead-time with mask=10, ch1 BRAKE -> ignored; ch1 stays COAST. Re-issued after ready=1 -> m_f[1]=m_b[1]=1 one edge later.
5. estop=1 while ch0 is in DEAD and ch1 is in BRAKE -> all outputs 0 next edge, busy=00, cmd_ready=0. Release -> channels stay COAST.
6. Duty change 3->12 mid-period on ch0 FWD -> current period keeps 3 high cycles; the following period has 12.

Source files
------------

// File: rtl/motor_pkg.sv
// Shared definitions for the multi-channel H-bridge PWM controller:
// command mode codes, channel state encoding and transition helpers.
package motor_pkg;

    localparam logic [1:0] MODE_COAST = 2'b00;
    localparam logic [1:0] MODE_FWD   = 2'b01;
    localparam logic [1:0] MODE_REV   = 2'b10;
    localparam logic [1:0] MODE_BRAKE = 2'b11;

    typedef enum logic [2:0] {
        ST_COAST = 3'd0,
        ST_FWD   = 3'd1,
        ST_REV   = 3'd2,
        ST_BRAKE = 3'd3,
        ST_DEAD  = 3'd4
    } ch_state_t;

    function automatic ch_state_t mode_to_state(input logic [1:0] mode);
        case (mode)
            MODE_FWD:   return ST_FWD;
            MODE_REV:   return ST_REV;
            MODE_BRAKE: return ST_BRAKE;
            default:    return ST_COAST;
        endcase
    endfunction

    // A dead-time gap is needed whenever the bridge moves between two
    // driven configurations, since either leg could briefly conduct twice.
    function automatic logic deadtime_needed(input ch_state_t cur, input logic [1:0] tgt);
        logic cur_driven;
        cur_driven = (cur == ST_FWD) || (cur == ST_REV) || (cur == ST_BRAKE);
        return cur_driven && (tgt != MODE_COAST) && (mode_to_state(tgt) != cur);
    endfunction

endpackage

// File: rtl/motor_channel.sv
// One H-bridge channel: mode FSM with dead-time insertion, double-buffered
// duty and registered bridge outputs.
module motor_channel
    import motor_pkg::*;
#(
    parameter int DUTY_W   = 8,
    parameter int DEADTIME = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              estop,
    input  logic              wr,
    input  logic [1:0]        mode,
    input  logic [DUTY_W-1:0] duty,
    input  logic              wrap,
    input  logic [DUTY_W-1:0] cnt,
    output logic              m_f,
    output logic              m_b,
    output ch_state_t         state
);

    localparam int DC_W = (DEADTIME > 1) ? $clog2(DEADTIME) : 1;

    ch_state_t         state_n;
    logic [1:0]        tgt, tgt_n;
    logic [DC_W-1:0]   dead, dead_n;
    logic [DUTY_W-1:0] shadow_duty, active_duty;
    logic              pwm_on;
    logic              f_n, b_n;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_COAST;
            tgt   <= MODE_COAST;
            dead  <= '0;
        end else begin
            state <= state_n;
            tgt   <= tgt_n;
            dead  <= dead_n;
        end
    end

    always_comb begin
        state_n = state;
        tgt_n   = tgt;
        dead_n  = dead;
        if (estop) begin
            state_n = ST_COAST;
            dead_n  = '0;
        end else if (wr && mode == MODE_COAST) begin
            state_n = ST_COAST;
            dead_n  = '0;
        end else if (state == ST_DEAD) begin
            if (dead == '0) begin
                state_n = mode_to_state(tgt);
            end else begin
                dead_n = dead - DC_W'(1);
            end
        end else if (wr) begin
            if (deadtime_needed(state, mode)) begin
                state_n = ST_DEAD;
                tgt_n   = mode;
                dead_n  = DC_W'(DEADTIME - 1);
            end else begin
                state_n = mode_to_state(mode);
            end
        end
    end

    // A write landing on the wrap edge goes straight to the active register.
    always_ff @(posedge clk) begin
        if (rst) begin
            shadow_duty <= '0;
            active_duty <= '0;
        end else begin
            if (wr) begin
                shadow_duty <= duty;
            end
            if (wrap) begin
                active_duty <= wr ? duty : shadow_duty;
            end
        end
    end

    assign pwm_on = (active_duty > cnt);

    always_comb begin
        f_n = ((state == ST_FWD) && pwm_on) || (state == ST_BRAKE);
        b_n = ((state == ST_REV) && pwm_on) || (state == ST_BRAKE);
    end

    always_ff @(posedge clk) begin
        if (rst || estop) begin
            m_f <= 1'b0;
            m_b <= 1'b0;
        end else begin
            m_f <= f_n;
            m_b <= b_n;
        end
    end

endmodule

// File: rtl/motor_pwm_ctrl.sv
// Multi-channel H-bridge driver: shared PWM timebase, command handshake and
// NUM_MOTORS independent channels.
module motor_pwm_ctrl
    import motor_pkg::*;
#(
    parameter int NUM_MOTORS = 2,
    parameter int DUTY_W     = 8,
    parameter int PWM_DIV    = 1,
    parameter int DEADTIME   = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         cmd_valid,
    output logic                         cmd_ready,
    input  logic [NUM_MOTORS-1:0]        cmd_mask,
    input  logic [2*NUM_MOTORS-1:0]      cmd_mode,
    input  logic [DUTY_W*NUM_MOTORS-1:0] cmd_duty,
    input  logic                         estop,
    output logic [NUM_MOTORS-1:0]        m_f,
    output logic [NUM_MOTORS-1:0]        m_b,
    output logic [NUM_MOTORS-1:0]        busy
);

    localparam int PRE_W = (PWM_DIV > 1) ? $clog2(PWM_DIV) : 1;
    localparam logic [DUTY_W-1:0] CNT_LAST = DUTY_W'((1 << DUTY_W) - 2);

    logic [PRE_W-1:0]  pre;
    logic [DUTY_W-1:0] cnt;
    logic              tick;
    logic              wrap;
    logic              accept;
    ch_state_t         ch_state [NUM_MOTORS];

    assign tick = (pre == PRE_W'(PWM_DIV - 1));
    assign wrap = tick && (cnt == CNT_LAST);

    always_ff @(posedge clk) begin
        if (rst || tick) begin
            pre <= '0;
        end else begin
            pre <= pre + PRE_W'(1);
        end
    end

    // Period is 2^DUTY_W-1 ticks so that full-scale duty means always on.
    always_ff @(posedge clk) begin
        if (rst || wrap) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= cnt + DUTY_W'(1);
        end
    end

    // Handshake: a command transfers on any edge where cmd_valid and cmd_ready
    // are both high; while cmd_ready is low the source must hold its command.
    assign cmd_ready = ~estop & ~|busy;
    assign accept    = cmd_valid & cmd_ready;

    for (genvar i = 0; i < NUM_MOTORS; i++) begin : g_ch
        motor_channel #(
            .DUTY_W   (DUTY_W),
            .DEADTIME (DEADTIME)
        ) u_ch (
            .clk   (clk),
            .rst   (rst),
            .estop (estop),
            .wr    (accept & cmd_mask[i]),
            .mode  (cmd_mode[2*i +: 2]),
            .duty  (cmd_duty[DUTY_W*i +: DUTY_W]),
            .wrap  (wrap),
            .cnt   (cnt),
            .m_f   (m_f[i]),
            .m_b   (m_b[i]),
            .state (ch_state[i])
        );
        assign busy[i] = (ch_state[i] == ST_DEAD);
    end

endmodule

// File: tb/tb_motor_pwm_ctrl.sv
// Bench for motor_pwm_ctrl: directed scenarios with hand-counted expectations
// plus randomized traffic checked every cycle against a behavioural model.
module tb_motor_pwm_ctrl;

    localparam int NM  = 2;
    localparam int DW  = 4;
    localparam int PD  = 1;
    localparam int DT  = 4;
    localparam int PER = (1 << DW) - 1;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       estop = 1'b0;
    logic [1:0] cmd_mask = '0;
    logic [3:0] cmd_mode = '0;
    logic [7:0] cmd_duty = '0;
    logic       cmd_ready;
    logic [1:0] m_f, m_b, busy;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    motor_pwm_ctrl #(
        .NUM_MOTORS (NM),
        .DUTY_W     (DW),
        .PWM_DIV    (PD),
        .DEADTIME   (DT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_mask  (cmd_mask),
        .cmd_mode  (cmd_mode),
        .cmd_duty  (cmd_duty),
        .estop     (estop),
        .m_f       (m_f),
        .m_b       (m_b),
        .busy      (busy)
    );

    // Model: st 0 coast, 1 fwd, 2 rev, 3 brake, 4 dead; left = dead cycles remaining.
    typedef struct {
        int st;
        int tgt;
        int left;
        int shadow;
        int act;
    } ch_m_t;

    ch_m_t      chm [NM];
    logic [1:0] ef_m = '0;
    logic [1:0] eb_m = '0;
    int         cyc_m = 0;
    bit         live = 1'b0;

    function automatic logic [1:0] busy_m();
        logic [1:0] b;
        for (int i = 0; i < NM; i++) b[i] = (chm[i].st == 4);
        return b;
    endfunction

    function automatic logic ready_m();
        return !estop && (busy_m() == 2'b00);
    endfunction

    function automatic ch_m_t ch_next(input ch_m_t c, input int i, input bit acc, input bit wrap);
        ch_m_t n;
        int    md;
        int    dty;
        bit    wr;
        n   = c;
        md  = int'(cmd_mode[2*i +: 2]);
        dty = int'(cmd_duty[4*i +: 4]);
        wr  = acc && cmd_mask[i];
        if (rst) return '{0, 0, 0, 0, 0};
        if (estop) begin
            n.st = 0;
            n.left = 0;
        end else if (c.st == 4) begin
            n.left = c.left - 1;
            if (n.left == 0) n.st = c.tgt;
        end else if (wr) begin
            if (md == 0 || c.st == 0 || c.st == md) begin
                n.st = md;
            end else begin
                n.st = 4;
                n.tgt = md;
                n.left = DT;
            end
        end
        if (wr) n.shadow = dty;
        if (wrap) n.act = wr ? dty : c.shadow;
        return n;
    endfunction

    always @(posedge clk) begin
        for (int i = 0; i < NM; i++) begin
            ef_m[i] <= !rst && !estop && ((chm[i].st == 1 && chm[i].act > cyc_m % PER) || chm[i].st == 3);
            eb_m[i] <= !rst && !estop && ((chm[i].st == 2 && chm[i].act > cyc_m % PER) || chm[i].st == 3);
            chm[i]  <= ch_next(chm[i], i, cmd_valid && ready_m(), (cyc_m % PER) == PER - 1);
        end
        cyc_m <= rst ? 0 : cyc_m + 1;
        live  <= 1'b1;
    end

    function automatic void check(input string name, input logic [7:0] got, input logic [7:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
        end
    endfunction

    always @(negedge clk) begin
        if (live) begin
            check("m_f", {6'd0, m_f}, {6'd0, ef_m});
            check("m_b", {6'd0, m_b}, {6'd0, eb_m});
            check("busy", {6'd0, busy}, {6'd0, busy_m()});
            check("cmd_ready", {7'd0, cmd_ready}, {7'd0, ready_m()});
        end
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_cmd(input logic [1:0] mask, input logic [3:0] mode, input logic [7:0] duty);
        int n;
        n = 0;
        while (!cmd_ready && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!cmd_ready) begin
            total++;
            bad++;
            $display("FAIL ready_timeout got=0 exp=1 t=%0t", $time);
        end
        cmd_valid = 1'b1;
        cmd_mask  = mask;
        cmd_mode  = mode;
        cmd_duty  = duty;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic count_high(input int ch, input bit back, input int n, output int hi);
        hi = 0;
        repeat (n) begin
            @(negedge clk);
            hi += back ? int'(m_b[ch]) : int'(m_f[ch]);
        end
    endtask

    initial begin
        int hi, h1, h2, nb, nr;

        // Reset
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_m_f", {6'd0, m_f}, 8'd0);
        check("rst_m_b", {6'd0, m_b}, 8'd0);
        check("rst_busy", {6'd0, busy}, 8'd0);
        check("rst_ready", {7'd0, cmd_ready}, 8'd1);

        // Forward PWM at duty 5, 15 and 0
        send_cmd(2'b01, 4'b0001, 8'h05);
        wait_cycles(17);
        count_high(0, 0, PER, hi);
        check("fwd_duty5", 8'(hi), 8'd5);
        send_cmd(2'b01, 4'b0001, 8'h0f);
        wait_cycles(17);
        count_high(0, 0, PER, hi);
        check("fwd_duty15", 8'(hi), 8'd15);
        send_cmd(2'b01, 4'b0001, 8'h00);
        wait_cycles(17);
        count_high(0, 0, PER, hi);
        check("fwd_duty0", 8'(hi), 8'd0);

        // FWD -> REV through dead-time; a ch1 command during it is ignored
        send_cmd(2'b01, 4'b0010, 8'h05);
        nb = 0;
        nr = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            nb += int'(busy[0]);
            nr += int'(!cmd_ready);
            if (k == 0) begin
                cmd_valid = 1'b1;
                cmd_mask  = 2'b10;
                cmd_mode  = 4'b1100;
                cmd_duty  = 8'h00;
            end
            if (k == 1) cmd_valid = 1'b0;
        end
        check("dead_busy_cycles", 8'(nb), 8'd4);
        check("dead_notready_cycles", 8'(nr), 8'd4);
        @(negedge clk);
        check("ch1_ignored", {6'd0, m_f[1], m_b[1]}, 8'd0);
        wait_cycles(17);
        count_high(0, 1, PER, hi);
        check("rev_duty5", 8'(hi), 8'd5);
        send_cmd(2'b10, 4'b1100, 8'h00);
        @(posedge clk);
        @(negedge clk);
        check("ch1_brake", {6'd0, m_f[1], m_b[1]}, 8'd3);

        // Emergency stop while ch0 is in dead-time and ch1 is braking
        send_cmd(2'b01, 4'b0001, 8'h05);
        estop = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("estop_m_f", {6'd0, m_f}, 8'd0);
        check("estop_m_b", {6'd0, m_b}, 8'd0);
        check("estop_busy", {6'd0, busy}, 8'd0);
        check("estop_ready", {7'd0, cmd_ready}, 8'd0);
        wait_cycles(3);
        estop = 1'b0;
        wait_cycles(20);
        @(negedge clk);
        check("estop_rel_m_f", {6'd0, m_f}, 8'd0);
        check("estop_rel_m_b", {6'd0, m_b}, 8'd0);
        check("estop_rel_ready", {7'd0, cmd_ready}, 8'd1);

        // Duty change 3 -> 12 mid-period takes effect from the next period
        send_cmd(2'b01, 4'b0001, 8'h03);
        wait_cycles(17);
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (cyc_m % PER == 0) break;
        end
        fork
            begin
                count_high(0, 0, PER, h1);
                count_high(0, 0, PER, h2);
            end
            begin
                repeat (6) @(posedge clk);
                #1;
                send_cmd(2'b01, 4'b0001, 8'h0c);
            end
        join
        check("mid_period_old", 8'(h1), 8'd3);
        check("mid_period_new", 8'(h2), 8'd12);

        // Randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk);
            #1;
            cmd_valid = ($urandom_range(0, 1) == 1);
            cmd_mask  = 2'($urandom_range(0, 3));
            cmd_mode  = 4'($urandom_range(0, 15));
            cmd_duty  = 8'($urandom_range(0, 255));
            estop     = ($urandom_range(0, 59) == 0) ? 1'b1 : (estop && ($urandom_range(0, 2) != 0));
            rst       = ($urandom_range(0, 499) == 0);
        end
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        estop = 1'b0;
        rst = 1'b0;
        wait_cycles(10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
